// File: rtl/any1_bitfield_unpacker.sv
// Sequential LSB-first bit-stream field reader: buffers 64-bit words and returns
// 1..64-bit fields, zero- or sign-extended like BFEXTU/BFEXT.
module any1_bitfield_unpacker #(
    parameter int DWIDTH = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [5:0]        req_width_i,
    input  logic              req_signed_i,
    output logic              fvalid_o,
    input  logic              fready_i,
    output logic [DWIDTH-1:0] field_o,
    output logic [7:0]        level_o
);

    localparam int BW = 2 * DWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t            r_state;
    logic [BW-1:0]     r_buf;
    logic [7:0]        r_lvl;
    logic [5:0]        r_width;
    logic              r_signed;
    logic              r_fvalid;
    logic [DWIDTH-1:0] r_field;

    logic [5:0]        w_code;
    logic [6:0]        w_w;
    logic              w_sgn_sel;
    logic              w_can;
    logic              w_extract;
    logic              w_push;
    logic [DWIDTH-1:0] w_low;
    logic [DWIDTH-1:0] w_mask;
    logic [DWIDTH-1:0] w_field;
    logic [BW-1:0]     w_shifted;
    logic [7:0]        w_lvl_mid;
    logic [BW-1:0]     w_buf_next;
    logic [7:0]        w_lvl_next;

    // In IDLE the live request drives extraction; in WAIT the latched one does.
    assign w_code    = (r_state == ST_IDLE) ? req_width_i  : r_width;
    assign w_sgn_sel = (r_state == ST_IDLE) ? req_signed_i : r_signed;
    assign w_w       = {1'b0, w_code} + 7'd1;
    assign w_can     = (r_lvl >= {1'b0, w_w});
    assign w_extract = !flush_i && w_can
                       && ((r_state == ST_IDLE && req_valid_i) || r_state == ST_WAIT);

    assign wready_o  = (r_lvl <= 8'd64) && !flush_i;
    assign w_push    = wvalid_i && wready_o;

    assign w_low     = r_buf[DWIDTH-1:0];
    assign w_mask    = {DWIDTH{1'b1}} >> (7'(DWIDTH) - w_w);
    assign w_field   = (w_low & w_mask)
                       | ((w_sgn_sel && w_low[w_code]) ? ~w_mask : {DWIDTH{1'b0}});

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_shifted  = r_buf;
        w_lvl_mid  = r_lvl;
        w_buf_next = r_buf;
        w_lvl_next = r_lvl;
        if (w_extract) begin
            w_shifted = r_buf >> w_w;
            w_lvl_mid = r_lvl - {1'b0, w_w};
        end
        w_buf_next = w_shifted;
        w_lvl_next = w_lvl_mid;
        // The shift happens first, so a same-cycle word lands at the reduced level.
        if (w_push) begin
            w_buf_next = w_shifted | ({{DWIDTH{1'b0}}, wdata_i} << w_lvl_mid);
            w_lvl_next = w_lvl_mid + 8'd64;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    // NOTE: the buffer is reset (not left undefined) because word insertion ORs into
    // it and relies on every bit at or above the level being zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_buf    <= '0;
            r_lvl    <= '0;
            r_width  <= '0;
            r_signed <= 1'b0;
            r_fvalid <= 1'b0;
            r_field  <= '0;
        end else if (flush_i) begin
            r_state  <= ST_IDLE;
            r_buf    <= '0;
            r_lvl    <= '0;
            r_fvalid <= 1'b0;
        end else begin
            r_buf <= w_buf_next;
            r_lvl <= w_lvl_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_width  <= req_width_i;
                        r_signed <= req_signed_i;
                        if (w_can) begin
                            r_field  <= w_field;
                            r_fvalid <= 1'b1;
                            r_state  <= ST_OUT;
                        end else begin
                            r_state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_can) begin
                        r_field  <= w_field;
                        r_fvalid <= 1'b1;
                        r_state  <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (fready_i) begin
                        r_fvalid <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_fvalid <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign fvalid_o    = r_fvalid;
    assign field_o     = r_field;
    assign level_o     = r_lvl;

endmodule
